// File: rtl/stack_pkg.sv
// Shared types and constants for the return-side stack pop unit.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int RET_WORDS = 2;
  localparam int RTI_WORDS = 3;
  localparam int FLAG_W    = 3;

  // Number of stack words a return pops: RTI also restores the flags word.
  function automatic logic [1:0] pop_words(input logic is_rti);
    return is_rti ? 2'(RTI_WORDS) : 2'(RET_WORDS);
  endfunction

endpackage

// File: rtl/stack_return_unit.sv
// Pops a return PC (RET) or a PC plus saved flags (RTI) from the downward
// growing data-memory stack, stalling the pipeline until a one-cycle
// redirect carrying PC, flags and the new SP is delivered.
module stack_return_unit
  import stack_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic              flush,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       ret_pc,
  output logic [FLAG_W-1:0] ret_flags,
  output logic              pc_valid,
  output logic              flags_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we,
  output logic              stall,
  output logic              underflow_err,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          n_q, n_d;
  logic [1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   cap_lo_q, cap_lo_d;
  logic [DATA_W-1:0]   cap_hi_q, cap_hi_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         ret_pc_q, ret_pc_d;
  logic [FLAG_W-1:0]   ret_flags_q, ret_flags_d;
  logic                pc_valid_q, pc_valid_d;
  logic                flags_valid_q, flags_valid_d;
  logic [ADDR_W-1:0]   sp_out_q, sp_out_d;
  logic                sp_we_q, sp_we_d;
  logic                underflow_q, underflow_d;
  logic [ADDR_W:0]     sp_sum;

  // Extra top bit of the new-SP sum flags a wrap past the top of memory.
  assign sp_sum = {1'b0, base_q} + (ADDR_W+1)'(n_q);

  // Next-state and registered-output logic for the pop sequencer.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    n_d           = n_q;
    idx_d         = idx_q;
    cap_lo_d      = cap_lo_q;
    cap_hi_d      = cap_hi_q;
    mem_rd_d      = mem_rd_q;
    mem_addr_d    = mem_addr_q;
    ret_pc_d      = ret_pc_q;
    ret_flags_d   = ret_flags_q;
    sp_out_d      = sp_out_q;
    pc_valid_d    = 1'b0;
    flags_valid_d = 1'b0;
    sp_we_d       = 1'b0;
    underflow_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && (ret_req || rti_req)) begin
          base_d     = sp_in;
          n_d        = pop_words(rti_req);
          idx_d      = 2'd0;
          state_d    = ISSUE;
          mem_rd_d   = 1'b1;
          mem_addr_d = sp_in + ADDR_W'(1);
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d    = IDLE;
          mem_rd_d   = 1'b0;
          mem_addr_d = '0;
        end else begin
          if (idx_q == 2'd1) cap_lo_d = mem_rdata;
          if (idx_q == 2'd2) cap_hi_d = mem_rdata;
          idx_d = idx_q + 2'd1;
          if (idx_q == n_q - 2'd1) begin
            state_d    = DRAIN;
            mem_rd_d   = 1'b0;
            mem_addr_d = '0;
          end else begin
            mem_addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(2);
          end
        end
      end
      DRAIN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (n_q == 2'(RTI_WORDS)) begin
            ret_pc_d      = {cap_hi_q, cap_lo_q};
            ret_flags_d   = mem_rdata[FLAG_W-1:0];
            flags_valid_d = 1'b1;
          end else begin
            ret_pc_d = {mem_rdata, cap_lo_q};
          end
          pc_valid_d  = 1'b1;
          sp_we_d     = 1'b1;
          sp_out_d    = sp_sum[ADDR_W-1:0];
          underflow_d = sp_sum[ADDR_W];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence without an SP write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      cap_lo_q      <= '0;
      cap_hi_q      <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      ret_pc_q      <= '0;
      ret_flags_q   <= '0;
      pc_valid_q    <= 1'b0;
      flags_valid_q <= 1'b0;
      sp_out_q      <= '0;
      sp_we_q       <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      cap_lo_q      <= cap_lo_d;
      cap_hi_q      <= cap_hi_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      ret_pc_q      <= ret_pc_d;
      ret_flags_q   <= ret_flags_d;
      pc_valid_q    <= pc_valid_d;
      flags_valid_q <= flags_valid_d;
      sp_out_q      <= sp_out_d;
      sp_we_q       <= sp_we_d;
      underflow_q   <= underflow_d;
    end
  end

  // Stall drops in DONE so the redirect and pipeline restart share a cycle.
  always_comb begin
    stall = reset && (((state_q == IDLE) && (ret_req || rti_req)) ||
                      (state_q == ISSUE) || (state_q == DRAIN));
  end

  assign busy          = (state_q != IDLE);
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign ret_pc        = ret_pc_q;
  assign ret_flags     = ret_flags_q;
  assign pc_valid      = pc_valid_q;
  assign flags_valid   = flags_valid_q;
  assign sp_out        = sp_out_q;
  assign sp_we         = sp_we_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_stack_return_unit.sv
// Bench for stack_return_unit: a word-addressed memory model answers reads
// one cycle later, and expected pops are computed from the stack layout.
module tb_stack_return_unit;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ret_req = 1'b0, rti_req = 1'b0, flush = 1'b0;
  logic [AW-1:0] sp_in = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   ret_pc;
  logic [2:0]    ret_flags;
  logic          pc_valid, flags_valid, sp_we, stall, underflow_err, busy;
  logic [AW-1:0] sp_out;

  logic [DW-1:0] mem [0:4095];

  int checks_total = 0;
  int checks_passed = 0;

  // Values the registered outputs should currently hold.
  logic [31:0]   exp_last_pc = '0;
  logic [2:0]    exp_last_flags = '0;
  logic [AW-1:0] exp_last_sp = '0;

  // Per-run observations gathered by run_pop.
  int            done_cyc, done2_cyc, pulse_cnt, fv_cnt, we_cnt, rd_cnt;
  logic [31:0]   obs_pc;
  logic [2:0]    obs_flags;
  logic          obs_fv, obs_uf, obs_we, obs2_fv;
  logic [AW-1:0] obs_sp, obs2_sp;
  logic [AW-1:0] obs_addr [0:7];
  logic [15:0]   stall_mask, busy_mask;

  stack_return_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .ret_req(ret_req), .rti_req(rti_req),
    .flush(flush), .sp_in(sp_in), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .ret_pc(ret_pc), .ret_flags(ret_flags),
    .pc_valid(pc_valid), .flags_valid(flags_valid), .sp_out(sp_out),
    .sp_we(sp_we), .stall(stall), .underflow_err(underflow_err), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Data memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [AW-1:0] wrap(input int a);
    return AW'(a % 4096);
  endfunction

  // Drives one request and records everything seen over a fixed window.
  task automatic run_pop(input logic r, input logic t, input logic [AW-1:0] sp,
                         input int flush_cyc, input int n_cycles, input int hold_until);
    done_cyc = -1; done2_cyc = -1; pulse_cnt = 0; fv_cnt = 0; we_cnt = 0; rd_cnt = 0;
    obs_pc = '0; obs_flags = '0; obs_fv = 0; obs_uf = 0; obs_we = 0; obs_sp = '0;
    obs2_fv = 0; obs2_sp = '0; stall_mask = '0; busy_mask = '0;
    ret_req = r; rti_req = t; sp_in = sp; flush = 1'b0;
    #1;
    stall_mask[0] = stall;
    busy_mask[0]  = busy;
    for (int c = 1; c <= n_cycles; c++) begin
      @(posedge clk); #1;
      ret_req = (c <= hold_until);
      rti_req = 1'b0;
      flush   = (c == flush_cyc);
      #1;
      if (mem_rd) begin
        if (rd_cnt < 8) obs_addr[rd_cnt] = mem_addr;
        rd_cnt++;
      end
      stall_mask[c] = stall;
      busy_mask[c]  = busy;
      if (pc_valid) begin
        pulse_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; obs_pc = ret_pc; obs_flags = ret_flags; obs_fv = flags_valid;
          obs_uf = underflow_err; obs_we = sp_we; obs_sp = sp_out;
        end else if (done2_cyc < 0) begin
          done2_cyc = c; obs2_fv = flags_valid; obs2_sp = sp_out;
        end
      end
      if (flags_valid) fv_cnt++;
      if (sp_we) we_cnt++;
    end
    flush = 1'b0; ret_req = 1'b0; rti_req = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks_total++;
    if ({mem_rd, pc_valid, flags_valid, sp_we, stall, underflow_err, busy} !== 7'b0)
      $display("[TB] FAIL reset_strobes: got %b want 0000000",
               {mem_rd, pc_valid, flags_valid, sp_we, stall, underflow_err, busy});
    else checks_passed++;
    checks_total++;
    if ({ret_pc, ret_flags, sp_out, mem_addr} !== '0)
      $display("[TB] FAIL reset_data: pc %h flags %b sp %h addr %h want all zero",
               ret_pc, ret_flags, sp_out, mem_addr);
    else checks_passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ret_basic();
    mem[12'hFFE] = 16'h1234; mem[12'hFFF] = 16'h0005;
    run_pop(1'b1, 1'b0, 12'hFFD, -1, 9, 0);
    checks_total++;
    if (done_cyc !== 4) $display("[TB] FAIL ret_latency: got %0d want 4", done_cyc); else checks_passed++;
    checks_total++;
    if (obs_pc !== 32'h0005_1234) $display("[TB] FAIL ret_pc: got %h want 00051234", obs_pc); else checks_passed++;
    checks_total++;
    if ({obs_sp, obs_we, obs_fv, obs_uf} !== {12'hFFF, 1'b1, 1'b0, 1'b0})
      $display("[TB] FAIL ret_sp: got sp %h we %b fv %b uf %b want fff 1 0 0", obs_sp, obs_we, obs_fv, obs_uf);
    else checks_passed++;
    checks_total++;
    if (rd_cnt !== 2 || obs_addr[0] !== 12'hFFE || obs_addr[1] !== 12'hFFF)
      $display("[TB] FAIL ret_addr: got %0d reads %h %h want 2 reads ffe fff", rd_cnt, obs_addr[0], obs_addr[1]);
    else checks_passed++;
    checks_total++;
    if (stall_mask[9:0] !== 10'b00_0000_1111)
      $display("[TB] FAIL ret_stall: got %b want 0000001111", stall_mask[9:0]);
    else checks_passed++;
    checks_total++;
    if (pulse_cnt !== 1 || we_cnt !== 1 || fv_cnt !== 0)
      $display("[TB] FAIL ret_pulses: got pc %0d we %0d fv %0d want 1 1 0", pulse_cnt, we_cnt, fv_cnt);
    else checks_passed++;
    exp_last_pc = 32'h0005_1234; exp_last_sp = 12'hFFF;
  endtask

  task automatic test_rti_basic();
    mem[12'hFFD] = 16'hBEEF; mem[12'hFFE] = 16'h0000; mem[12'hFFF] = 16'hFFF6;
    run_pop(1'b0, 1'b1, 12'hFFC, -1, 9, 0);
    checks_total++;
    if (done_cyc !== 5) $display("[TB] FAIL rti_latency: got %0d want 5", done_cyc); else checks_passed++;
    checks_total++;
    if ({obs_pc, obs_flags} !== {32'h0000_BEEF, 3'b110})
      $display("[TB] FAIL rti_pc_flags: got %h %b want 0000beef 110", obs_pc, obs_flags);
    else checks_passed++;
    checks_total++;
    if ({obs_sp, obs_fv, obs_uf} !== {12'hFFF, 1'b1, 1'b0})
      $display("[TB] FAIL rti_sp: got sp %h fv %b uf %b want fff 1 0", obs_sp, obs_fv, obs_uf);
    else checks_passed++;
    checks_total++;
    if (stall_mask[9:0] !== 10'b00_0001_1111)
      $display("[TB] FAIL rti_stall: got %b want 0000011111", stall_mask[9:0]);
    else checks_passed++;
    exp_last_pc = 32'h0000_BEEF; exp_last_flags = 3'b110; exp_last_sp = 12'hFFF;
  endtask

  task automatic test_underflow();
    mem[12'hFFF] = 16'hA5A5; mem[12'h000] = 16'h0123;
    run_pop(1'b1, 1'b0, 12'hFFE, -1, 9, 0);
    checks_total++;
    if (rd_cnt !== 2 || obs_addr[0] !== 12'hFFF || obs_addr[1] !== 12'h000)
      $display("[TB] FAIL wrap_addr: got %0d reads %h %h want 2 reads fff 000", rd_cnt, obs_addr[0], obs_addr[1]);
    else checks_passed++;
    checks_total++;
    if ({obs_pc, obs_sp, obs_uf} !== {32'h0123_A5A5, 12'h000, 1'b1})
      $display("[TB] FAIL wrap_result: got pc %h sp %h uf %b want 0123a5a5 000 1", obs_pc, obs_sp, obs_uf);
    else checks_passed++;
    exp_last_pc = 32'h0123_A5A5; exp_last_sp = 12'h000;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] sp;
    sp = 12'h400;
    run_pop(1'b1, 1'b1, sp, -1, 11, 6);
    checks_total++;
    if (done_cyc !== 5 || obs_fv !== 1'b1 || rd_cnt !== 5)
      $display("[TB] FAIL both_req: got done %0d fv %b reads %0d want 5 1 5", done_cyc, obs_fv, rd_cnt);
    else checks_passed++;
    checks_total++;
    if (obs_pc !== {mem[sp+2], mem[sp+1]} || obs_flags !== mem[sp+3][2:0])
      $display("[TB] FAIL both_data: got %h %b want %h %b", obs_pc, obs_flags,
               {mem[sp+2], mem[sp+1]}, mem[sp+3][2:0]);
    else checks_passed++;
    checks_total++;
    if (stall_mask[6:5] !== 2'b10)
      $display("[TB] FAIL held_stall: got %b want 10", stall_mask[6:5]);
    else checks_passed++;
    checks_total++;
    if (done2_cyc !== 10 || obs2_fv !== 1'b0 || obs2_sp !== sp + 12'd2)
      $display("[TB] FAIL held_accept: got done %0d fv %b sp %h want 10 0 %h", done2_cyc, obs2_fv, obs2_sp, sp + 12'd2);
    else checks_passed++;
    exp_last_pc = {mem[sp+2], mem[sp+1]}; exp_last_flags = mem[sp+3][2:0]; exp_last_sp = sp + 12'd2;
  endtask

  task automatic test_flush_drain();
    run_pop(1'b1, 1'b0, 12'h123, 3, 9, 0);
    checks_total++;
    if (pulse_cnt !== 0 || we_cnt !== 0)
      $display("[TB] FAIL flush_pulses: got pc %0d we %0d want 0 0", pulse_cnt, we_cnt);
    else checks_passed++;
    checks_total++;
    if (ret_pc !== exp_last_pc || sp_out !== exp_last_sp)
      $display("[TB] FAIL flush_hold: got %h %h want %h %h", ret_pc, sp_out, exp_last_pc, exp_last_sp);
    else checks_passed++;
    checks_total++;
    if (busy_mask[4:3] !== 2'b01)
      $display("[TB] FAIL flush_idle: got busy %b want 01", busy_mask[4:3]);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    ret_req = 1'b1; sp_in = 12'h200;
    @(posedge clk); #1;
    ret_req = 1'b0;
    reset = 1'b0;
    #1;
    checks_total++;
    if ({mem_rd, busy, stall, pc_valid, sp_we, mem_addr, ret_pc, sp_out, ret_flags} !== '0)
      $display("[TB] FAIL reset_mid: rd %b busy %b stall %b addr %h pc %h sp %h want all zero",
               mem_rd, busy, stall, mem_addr, ret_pc, sp_out);
    else checks_passed++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    exp_last_pc = '0; exp_last_flags = '0; exp_last_sp = '0;
    mem[12'h201] = 16'hCAFE; mem[12'h202] = 16'h0042;
    run_pop(1'b1, 1'b0, 12'h200, -1, 9, 0);
    checks_total++;
    if (done_cyc !== 4 || obs_pc !== 32'h0042_CAFE || obs_sp !== 12'h202)
      $display("[TB] FAIL after_reset: got done %0d pc %h sp %h want 4 0042cafe 202", done_cyc, obs_pc, obs_sp);
    else checks_passed++;
    exp_last_pc = 32'h0042_CAFE; exp_last_sp = 12'h202;
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int kind, n, f, reads, sp;
      logic eff;
      logic [31:0] e_pc;
      logic [2:0] e_flags;
      kind = $urandom_range(0, 2);
      n = (kind == 0) ? 2 : 3;
      sp = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) == 0) sp = 4095 - $urandom_range(0, 3);
      for (int k = 1; k <= 3; k++) mem[(sp + k) % 4096] = 16'($urandom);
      f = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 2) : -1;
      eff = (f >= 1) && (f <= n + 1);
      reads = eff ? ((f < n) ? f : n) : n;
      e_pc = {mem[(sp + 2) % 4096], mem[(sp + 1) % 4096]};
      e_flags = (n == 3) ? mem[(sp + 3) % 4096][2:0] : exp_last_flags;
      run_pop(kind != 1, kind != 0, AW'(sp), f, 9, 0);
      checks_total++;
      if (rd_cnt !== reads) $display("[TB] FAIL rnd_reads[%0d]: got %0d want %0d", it, rd_cnt, reads);
      else checks_passed++;
      for (int k = 0; k < reads && k < rd_cnt; k++) begin
        checks_total++;
        if (obs_addr[k] !== wrap(sp + 1 + k))
          $display("[TB] FAIL rnd_addr[%0d.%0d]: got %h want %h", it, k, obs_addr[k], wrap(sp + 1 + k));
        else checks_passed++;
      end
      checks_total++;
      if (stall_mask[9:0] !== (eff ? 10'((1 << (f + 1)) - 1) : 10'((1 << (n + 2)) - 1)))
        $display("[TB] FAIL rnd_stall[%0d]: got %b flush %0d n %0d", it, stall_mask[9:0], f, n);
      else checks_passed++;
      if (eff) begin
        checks_total++;
        if (pulse_cnt !== 0 || we_cnt !== 0 || ret_pc !== exp_last_pc || ret_flags !== exp_last_flags || sp_out !== exp_last_sp)
          $display("[TB] FAIL rnd_flush[%0d]: pulses %0d we %0d pc %h want 0 0 %h", it, pulse_cnt, we_cnt, ret_pc, exp_last_pc);
        else checks_passed++;
      end else begin
        checks_total++;
        if (done_cyc !== n + 2 || pulse_cnt !== 1 || obs_we !== 1'b1 || obs_fv !== (n == 3))
          $display("[TB] FAIL rnd_timing[%0d]: done %0d pulses %0d we %b fv %b want %0d 1 1 %0d",
                   it, done_cyc, pulse_cnt, obs_we, obs_fv, n + 2, n == 3);
        else checks_passed++;
        checks_total++;
        if (obs_pc !== e_pc || obs_flags !== e_flags || obs_sp !== wrap(sp + n) || obs_uf !== (sp + n > 4095))
          $display("[TB] FAIL rnd_data[%0d]: pc %h flags %b sp %h uf %b want %h %b %h %0d",
                   it, obs_pc, obs_flags, obs_sp, obs_uf, e_pc, e_flags, wrap(sp + n), sp + n > 4095);
        else checks_passed++;
        exp_last_pc = e_pc; exp_last_flags = e_flags; exp_last_sp = wrap(sp + n);
      end
    end
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    test_reset();
    test_ret_basic();
    test_rti_basic();
    test_underflow();
    test_back_to_back();
    test_flush_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/stack_return_unit.md
Name: stack_return_unit

Overview:
Return-side companion to the memory stage's interrupt/call push path. On RET it pops a 32-bit return PC from the data-memory stack. On RTI it pops the PC and then the saved flags. Each pop is a multi-cycle read sequence; the unit stalls the pipeline until a single-cycle redirect (PC, flags, new SP) is delivered.

Parameters:
ADDR_W, 12, data-memory word-address width; SP arithmetic is modulo 2^ADDR_W
DATA_W, 16, memory word width; fixed at 16 for the 32-bit PC split

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
ret_req  in  1  RET in memory stage; sampled only in IDLE
rti_req  in  1  RTI in memory stage; sampled only in IDLE; wins over ret_req
flush  in  1  squash the in-flight sequence
sp_in  in  ADDR_W  current SP, points to the next free slot; stack grows downward
mem_rd  out  1  read strobe to data memory
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd
ret_pc  out  32  popped PC
ret_flags  out  3  popped flags, taken from word bits [2:0]
pc_valid  out  1  one-cycle redirect pulse
flags_valid  out  1  one-cycle pulse, RTI only, coincident with pc_valid
sp_out  out  ADDR_W  updated SP
sp_we  out  1  SP write strobe, coincident with pc_valid
stall  out  1  freeze upstream stages
underflow_err  out  1  pulse with pc_valid when SP wrapped
busy  out  1  state != IDLE

Behaviour:
- Stack layout, written by the push side:
  - interrupt pushes flags, then PC[31:16], then PC[15:0]
  - call pushes PC[31:16], then PC[15:0]
  - pop order is therefore lo, hi, [flags] at base+1, base+2, base+3
- Reset (reset=0): state IDLE. All outputs 0; internal base, count and capture registers 0. Reset mid-sequence aborts it with no sp_we.
- FSM states and transitions:
  - IDLE: on (ret_req|rti_req), latch base=sp_in, n=3 if rti_req else 2, idx=0; go to ISSUE.
  - ISSUE: mem_rd=1, mem_addr=base+1+idx. Capture mem_rdata for word idx-1 when idx>0. idx++. When idx==n-1, go to DRAIN.
  - DRAIN: mem_rd=0; capture word n-1; go to DONE.
  - DONE: pc_valid=1; flags_valid=(n==3); sp_we=1; sp_out=base+n (wraps); go to IDLE.
- Latency: request sampled at edge E0; DONE is cycle n+2 after E0 (RET: 4, RTI: 5).
- ret_pc, ret_flags and sp_out are registered and hold their last value until the next DONE.
- stall is combinational:
  - 1 in IDLE while a request is present
  - 1 in ISSUE and DRAIN
  - 0 in DONE, so the redirect and the pipeline restart share a cycle
- Requests arriving in ISSUE, DRAIN or DONE are ignored. The pipeline is stalled then, so the requester holds them.
- Simultaneous ret_req and rti_req: treated as RTI.
- flush in ISSUE or DRAIN: go to IDLE next edge; no pulses, no sp_we, registered outputs unchanged. flush in DONE is ignored (the redirect completes). flush in IDLE blocks acceptance that cycle.
- underflow_err=1 in DONE iff base+n > 2^ADDR_W-1; addresses and sp_out wrap modulo 2^ADDR_W.
- Flags word: bits [15:3] ignored.

Decomposition:
- Package stack_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE}
  - RET_WORDS=2, RTI_WORDS=3
  - FLAG_W=3
- A single file is sufficient; no sub-module.

Test Plan:
- RET, sp_in=0x0FFD, mem[0x0FFE]=0x1234, mem[0x0FFF]=0x0005 -> mem_addr 0x0FFE then 0x0FFF. pc_valid in cycle 4 with ret_pc=0x00051234, sp_out=0x0FFF, flags_valid=0, underflow_err=0. stall high cycles 0-3.
- RTI, sp_in=0x0FFC, mem[0x0FFD]=0xBEEF, mem[0x0FFE]=0x0000, mem[0x0FFF]=0xFFF6 -> pc_valid and flags_valid in cycle 5 with ret_pc=0x0000BEEF, ret_flags=3'b110, sp_out=0x0FFF.
- RET with sp_in=0x0FFE -> addresses 0x0FFF, 0x0000; sp_out=0x0000; underflow_err=1 with pc_valid.
- ret_req=rti_req=1 together -> three reads, flags_valid=1. A second ret_req held during the sequence is accepted only in the cycle after DONE.
- flush asserted in the DRAIN cycle -> no pc_valid, no sp_we, ret_pc keeps its previous value, IDLE next cycle.
- reset pulled low during ISSUE -> all outputs 0 immediately. After release, a new RET completes normally.
